dostring_frame_ctrl: RTL
========================

// Module: dostring_frame_ctrl
// PURPOSE
//  Sequences full APA102-style LED-strip refreshes on the dostring clock domain.
//  Per frame: start frame, NUM_LEDS pixel frames, end frame; drives mosi/sck.
//  Fetches each pixel from an external pixel source over a req/valid handshake.
//  Frames start on a start pulse or on an internal refresh timer.
// PARAMETERS
//  NUM_LEDS        60     pixels per strip (>=1); ADDR_W = $clog2(NUM_LEDS), min 1
//  CLK_DIV         4      dostring_clk cycles per sck half-period (>=1)
//  GAP_CYCLES      16     idle cycles between end of one frame and the next start
//  REFRESH_CYCLES  0      auto-start period in cycles; 0 = auto-start disabled
// PORTS
//  dostring_clk  in   1       block clock
//  my_reset_n    in   1       asynchronous active-low reset
//  start         in   1       1-cycle request for one frame refresh
//  brightness    in   5       global brightness; sampled when a frame starts
//  pix_req       out  1       pixel request; held until accepted
//  pix_addr      out  ADDR_W  pixel index 0..NUM_LEDS-1; stable while pix_req=1
//  pix_valid     in   1       pixel source ready; accepted when pix_req&pix_valid
//  pix_data      in   24      {R[23:16],G[15:8],B[7:0]}
//  mosi          out  1       serial data, MSB first
//  sck           out  1       serial clock, idle low
//  busy          out  1       high from frame start to end of GAP
//  done          out  1       1-cycle pulse after last end-frame bit completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; mosi=0, sck=0, pix_req=0, busy=0, done=0;
//   pix_addr=0, refresh timer=0, pending=0. Outputs are registered.
//  States: IDLE -> START_FRM -> FETCH -> PIXEL -> (FETCH | END_FRM) -> GAP -> IDLE.
//  IDLE: on start=1, or refresh timer reaching REFRESH_CYCLES-1, or pending=1:
//   latch brightness, clear pending, go to START_FRM next cycle; busy=1.
//  Bit timing: mosi is set while sck low; sck low CLK_DIV cycles, then high
//   CLK_DIV cycles; strip samples on sck rise. One bit = 2*CLK_DIV cycles.
//   First bit of a frame is on mosi the cycle after start is sampled.
//  START_FRM: 32 bits of 0.
//  FETCH: pix_req=1 with pix_addr=current index; sck held low, mosi held, no edges
//   until pix_valid=1. On accept load word {3'b111,brightness,B,G,R}, pix_req=0
//   next cycle, go to PIXEL. Valid in the accept cycle is used as-is (zero wait OK).
//  PIXEL: shift 32 bits. After bit 31: if index==NUM_LEDS-1 go END_FRM, else index+1,
//   FETCH. Index wraps to 0 at frame start; never exceeds NUM_LEDS-1.
//  END_FRM: END_BITS=8*ceil(NUM_LEDS/16) bits of 1, then mosi=0, done=1 for 1 cycle.
//  GAP: GAP_CYCLES cycles, sck=0, mosi=0; then IDLE, busy=0 on entry to IDLE.
//  Total sck rises per frame = 32 + 32*NUM_LEDS + END_BITS exactly, regardless of stalls.
//  start while busy=1: sets pending (one deep; further starts are dropped); a new
//   frame begins the cycle after GAP ends. start ignored in the cycle of reset release.
//  Refresh timer: free-runs in all states, restarts at 0 on expiry; expiry while busy
//   sets pending like start. Timer fully disabled when REFRESH_CYCLES=0.
//  pix_valid with pix_req=0 is ignored. brightness changes mid-frame have no effect.
// TESTING (NUM_LEDS=4, CLK_DIV=2, GAP_CYCLES=16, REFRESH_CYCLES=0 unless stated)
//  1 start pulse, pix_valid tied 1 -> 168 sck rises; first 32 mosi=0; last 8 mosi=1;
//    done pulses once; busy falls 16 cycles after done.
//  2 brightness=5'h1F, pix_data=24'hFF0000 all pixels -> each pixel word
//    captured on sck rise = 32'hFF0000FF; brightness=5'h03 -> 32'hE30000FF.
//  3 pix_valid delayed 10 cycles on pixel 2 -> sck low throughout stall, pix_addr=2
//    stable, pix_req high; still exactly 168 rises and correct data.
//  4 start pulsed 3 times during frame -> exactly one extra frame, beginning the cycle
//    after GAP ends; 336 total rises.
//  5 my_reset_n low mid pixel 1 -> same cycle sck=0, mosi=0, pix_req=0, busy=0;
//    after release and start, a clean 168-rise frame with pix_addr from 0.
//  6 REFRESH_CYCLES=2000, no start -> frames start at cycles 1999, 3999 after reset;
//    done pulse count matches frame count over 10000 cycles.

Source files
------------

// File: rtl/dostring_frame_ctrl_if.sv
// Pixel fetch handshake between the frame controller and a pixel source.
// master: drives pix_req/pix_addr; slave: answers with pix_valid/pix_data.
interface dostring_frame_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_valid;
  logic [23:0]       pix_data;

  modport master (
    output pix_req, pix_addr,
    input  pix_valid, pix_data
  );

  modport slave (
    input  pix_req, pix_addr,
    output pix_valid, pix_data
  );
endinterface

// File: rtl/dostring_frame_ctrl.sv
// APA102-style strip refresh sequencer: start frame, pixel frames, end frame.
// Ports: dostring_clk, my_reset_n, start, brightness, pix (master), mosi, sck, busy, done.
module dostring_frame_ctrl #(
  parameter int NUM_LEDS       = 60,
  parameter int CLK_DIV        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                  dostring_clk,
  input  logic                  my_reset_n,
  input  logic                  start,
  input  logic [4:0]            brightness,
  dostring_frame_ctrl_if.master pix,
  output logic                  mosi,
  output logic                  sck,
  output logic                  busy,
  output logic                  done
);

  localparam int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int END_BITS = 8 * ((NUM_LEDS + 15) / 16);
  localparam int BC_MAX   = (END_BITS > 32) ? END_BITS : 32;
  localparam int BC_W     = $clog2(BC_MAX);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMR_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_PIXEL,
    S_END,
    S_GAP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMR_W-1:0]  timer;
  logic [4:0]        bright;
  logic [31:0]       shreg;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              pending;
  logic              armed;

  logic start_ok;
  logic tick;
  logic div_end;
  logic bit_end;
  logic last32;
  logic last_pix;
  logic [31:0] word;

  assign pix.pix_req  = req_q;
  assign pix.pix_addr = addr_q;

  // armed masks a start seen on the first edge after reset release
  assign start_ok = start & armed;
  assign tick     = (REFRESH_CYCLES != 0) &&
                    (timer == TMR_W'(REFRESH_CYCLES - 1));
  assign div_end  = div_cnt == DIV_W'(CLK_DIV - 1);
  assign bit_end  = sck & div_end;
  assign last32   = bit_cnt == BC_W'(31);
  assign last_pix = addr_q == ADDR_W'(NUM_LEDS - 1);
  assign word     = {3'b111, bright,
                     pix.pix_data[7:0],
                     pix.pix_data[15:8],
                     pix.pix_data[23:16]};

  always_ff @(posedge dostring_clk or negedge my_reset_n) begin
    if (!my_reset_n) begin
      timer <= '0;
    end else if (REFRESH_CYCLES != 0) begin
      timer <= tick ? '0 : timer + 1'b1;
    end
  end

  always_ff @(posedge dostring_clk or negedge my_reset_n) begin
    if (!my_reset_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      bright  <= '0;
      shreg   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      pending <= 1'b0;
      armed   <= 1'b0;
      mosi    <= 1'b0;
      sck     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      if (state != S_IDLE && (start_ok || tick))
        pending <= 1'b1;

      // sck toggles every CLK_DIV cycles in the shifting states
      if (state == S_START || state == S_PIXEL || state == S_END) begin
        if (div_end) begin
          div_cnt <= '0;
          sck     <= ~sck;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (start_ok || tick || pending) begin
            bright  <= brightness;
            pending <= 1'b0;
            busy    <= 1'b1;
            mosi    <= 1'b0;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            if (last32) begin
              req_q <= 1'b1;
              state <= S_FETCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (pix.pix_valid) begin
            shreg   <= word;
            mosi    <= word[31];
            req_q   <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= S_PIXEL;
          end
        end
        S_PIXEL: begin
          if (bit_end) begin
            if (!last32) begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= shreg[30];
              shreg   <= {shreg[30:0], 1'b0};
            end else if (last_pix) begin
              bit_cnt <= '0;
              mosi    <= 1'b1;
              state   <= S_END;
            end else begin
              addr_q <= addr_q + 1'b1;
              req_q  <= 1'b1;
              state  <= S_FETCH;
            end
          end
        end
        S_END: begin
          if (bit_end) begin
            if (bit_cnt == BC_W'(END_BITS - 1)) begin
              mosi    <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_GAP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
